// File: rtl/screen_sequencer_pkg.sv
// Shared constants for the screen sequencer: screen indices, FSM encodings, helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 8
`endif

package screen_sequencer_pkg;

    localparam int NUM_SCREENS = 3;

    localparam logic [1:0] SCR_START = 2'd0;
    localparam logic [1:0] SCR_GAME  = 2'd1;
    localparam logic [1:0] SCR_OVER  = 2'd2;

    typedef enum logic [1:0] {
        ST_CLEAR    = 2'd0,
        ST_WAIT_REL = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    function automatic logic [1:0] next_screen(input logic [1:0] idx);
        return (idx == SCR_OVER) ? SCR_START : idx + 2'd1;
    endfunction

    // All screens held in reset except the one at idx.
    function automatic logic [2:0] release_mask(input logic [1:0] idx);
        return ~(3'b001 << idx);
    endfunction

endpackage

// File: rtl/screen_fb_clear.sv
// Clear-pass address generator: walks 0..FB_WORDS-1 while enabled, flags the last word.
// Latency: addr/last are combinational views of the counter; counter steps once per enabled cycle.
// Backpressure: none; the pass always advances one word per enabled cycle.
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 8
`endif

module screen_fb_clear #(
    parameter int FB_WORDS = 2**`DISP_ADDR_WIDTH,
    parameter int AW       = `DISP_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic          last
);

    // One extra bit so a full 2**AW pass terminates without wrapping.
    localparam logic [AW:0] LAST_IDX = (AW+1)'(FB_WORDS - 1);

    logic [AW:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + (AW+1)'(1);
        end
    end

    assign we   = en;
    assign addr = cnt[AW-1:0];
    assign last = (cnt == LAST_IDX);

endmodule

// File: rtl/screen_sequencer.sv
// Grants the framebuffer write port to one of START/GAME/OVER, optional clear between screens (SCREEN_SEQ_CLEAR_EN).
// Latency: 1 cycle screen-to-fb passthrough; FB_WORDS-cycle clear pass plus 1 WAIT_REL cycle between screens.
// Backpressure: none; writes from non-selected screens are dropped, keys held stall entry to RUN.
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 8
`endif

module screen_sequencer
    import screen_sequencer_pkg::*;
#(
    parameter int          FB_WORDS   = 2**`DISP_ADDR_WIDTH,
    parameter logic [31:0] CLEAR_WORD = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [25:0]                   key_status,
    input  logic [2:0]                    s_we,
    input  logic [3*`DISP_ADDR_WIDTH-1:0] s_addr,
    input  logic [3*32-1:0]               s_wdata,
    input  logic [2:0]                    s_done,
    output logic [2:0]                    screen_rst,
    output logic                          fb_we,
    output logic [`DISP_ADDR_WIDTH-1:0]   fb_addr,
    output logic [31:0]                   fb_wdata,
    output logic [1:0]                    active_screen
);

    localparam int AW = `DISP_ADDR_WIDTH;

    state_t     state;
    logic [1:0] cur;
    logic       run_first;

    logic          sel_we;
    logic          sel_done;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;

    always_comb begin
        sel_we    = s_we[0];
        sel_done  = s_done[0];
        sel_addr  = s_addr[0*AW +: AW];
        sel_wdata = s_wdata[0*32 +: 32];
        case (cur)
            SCR_GAME: begin
                sel_we    = s_we[1];
                sel_done  = s_done[1];
                sel_addr  = s_addr[1*AW +: AW];
                sel_wdata = s_wdata[1*32 +: 32];
            end
            SCR_OVER: begin
                sel_we    = s_we[2];
                sel_done  = s_done[2];
                sel_addr  = s_addr[2*AW +: AW];
                sel_wdata = s_wdata[2*32 +: 32];
            end
            default: ;
        endcase
    end

`ifdef SCREEN_SEQ_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;

    logic          clr_we;
    logic          clr_last;
    logic [AW-1:0] clr_addr;

    screen_fb_clear #(
        .FB_WORDS (FB_WORDS),
        .AW       (AW)
    ) u_fb_clear (
        .clk   (clk),
        .reset (reset),
        .en    (state == ST_CLEAR),
        .we    (clr_we),
        .addr  (clr_addr),
        .last  (clr_last)
    );
`else
    localparam state_t RESET_STATE = ST_WAIT_REL;

    logic unused_clear_cfg;
    assign unused_clear_cfg = ^{CLEAR_WORD, FB_WORDS};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RESET_STATE;
            cur        <= SCR_START;
            run_first  <= 1'b0;
            screen_rst <= 3'b111;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_wdata   <= '0;
        end else begin
            case (state)
`ifdef SCREEN_SEQ_CLEAR_EN
                ST_CLEAR: begin
                    fb_we    <= clr_we;
                    fb_addr  <= clr_addr;
                    fb_wdata <= CLEAR_WORD;
                    if (clr_last) begin
                        state <= ST_WAIT_REL;
                    end
                end
`endif
                ST_WAIT_REL: begin
                    fb_we <= 1'b0;
                    if (key_status == 26'd0) begin
                        state      <= ST_RUN;
                        run_first  <= 1'b1;
                        screen_rst <= release_mask(cur);
                    end
                end
                ST_RUN: begin
                    fb_we     <= sel_we;
                    fb_addr   <= sel_addr;
                    fb_wdata  <= sel_wdata;
                    run_first <= 1'b0;
                    // First RUN cycle the screen is still leaving reset; its done is not trusted yet.
                    if (!run_first && sel_done) begin
                        cur        <= next_screen(cur);
                        state      <= RESET_STATE;
                        screen_rst <= 3'b111;
                    end
                end
                default: begin
                    state      <= RESET_STATE;
                    screen_rst <= 3'b111;
                    fb_we      <= 1'b0;
                end
            endcase
        end
    end

    assign active_screen = cur;

endmodule

// File: tb/tb_screen_sequencer.sv
// Randomized scoreboard bench for screen_sequencer with a phase-level reference model.
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 8
`endif

module tb_screen_sequencer;

    localparam int          AW  = `DISP_ADDR_WIDTH;
    localparam int          FBW = 16;
    localparam logic [31:0] CW  = 32'h0000_0000;
`ifdef SCREEN_SEQ_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    localparam int PH_CLR  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_RUN  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [25:0]       key_status;
    logic [2:0]        s_we;
    logic [3*AW-1:0]   s_addr;
    logic [95:0]       s_wdata;
    logic [2:0]        s_done;
    logic [2:0]        screen_rst;
    logic              fb_we;
    logic [AW-1:0]     fb_addr;
    logic [31:0]       fb_wdata;
    logic [1:0]        active_screen;

    screen_sequencer #(
        .FB_WORDS   (FBW),
        .CLEAR_WORD (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_status    (key_status),
        .s_we          (s_we),
        .s_addr        (s_addr),
        .s_wdata       (s_wdata),
        .s_done        (s_done),
        .screen_rst    (screen_rst),
        .fb_we         (fb_we),
        .fb_addr       (fb_addr),
        .fb_wdata      (fb_wdata),
        .active_screen (active_screen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [1:0]    active;
        logic [2:0]    rst;
        bit            chk_dat;
        int            due;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    // Reference model: which phase the sequencer is in, next clear word, screen, age in RUN.
    int m_ph;
    int m_idx;
    int m_cur;
    int m_age;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic model_step(input bit r, input logic [25:0] k, input logic [2:0] we,
                              input logic [3*AW-1:0] a, input logic [95:0] d,
                              input logic [2:0] dn, output exp_t e);
        e.we = 1'b0; e.addr = '0; e.data = '0; e.chk_dat = 1'b0;
        if (r) begin
            m_ph  = CLEAR_EN ? PH_CLR : PH_WAIT;
            m_idx = 0;
            m_cur = 0;
            e.chk_dat = 1'b1;
        end else if (m_ph == PH_CLR) begin
            e.we = 1'b1; e.addr = AW'(m_idx); e.data = CW; e.chk_dat = 1'b1;
            m_idx++;
            if (m_idx == FBW) begin
                m_ph  = PH_WAIT;
                m_idx = 0;
            end
        end else if (m_ph == PH_WAIT) begin
            if (k == 26'd0) begin
                m_ph  = PH_RUN;
                m_age = 0;
            end
        end else begin
            e.we   = we[m_cur];
            e.addr = a[m_cur*AW +: AW];
            e.data = d[m_cur*32 +: 32];
            e.chk_dat = e.we;
            if (m_age >= 1 && dn[m_cur]) begin
                m_cur = (m_cur + 1) % 3;
                m_ph  = CLEAR_EN ? PH_CLR : PH_WAIT;
            end
            m_age++;
        end
        e.active = 2'(m_cur);
        e.rst    = (m_ph == PH_RUN) ? ~(3'b001 << m_cur) : 3'b111;
    endtask

    task automatic drive(input bit r, input logic [25:0] k, input logic [2:0] we,
                         input logic [3*AW-1:0] a, input logic [95:0] d, input logic [2:0] dn);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; key_status = k; s_we = we; s_addr = a; s_wdata = d; s_done = dn;
        model_step(r, k, we, a, d, dn, e);
        e.due = cycle + 1;
        exp_q.push_back(e);
    endtask

    function automatic logic [3*AW-1:0] rand_addr();
        logic [3*AW-1:0] v;
        for (int i = 0; i < 3; i++) v[i*AW +: AW] = AW'($urandom);
        return v;
    endfunction

    function automatic logic [95:0] rand_data();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic go(input bit r, input logic [25:0] k, input logic [2:0] dn);
        drive(r, k, 3'($urandom), rand_addr(), rand_data(), dn);
    endtask

    task automatic run_to_run(input int budget);
        int n = 0;
        while (m_ph != PH_RUN && n < budget) begin
            go(1'b0, 26'd0, 3'b000);
            n++;
        end
        if (m_ph != PH_RUN) begin
            checks++; errors++;
            $display("FAIL run_entry_timeout: got phase %0d expected %0d", m_ph, PH_RUN);
        end
    endtask

    // Monitor: every cycle the DUT presents a registered output set; compare with the oldest due entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].due <= cycle) begin
                e = exp_q.pop_front();
                check("fb_we", 32'(fb_we), 32'(e.we));
                check("active_screen", 32'(active_screen), 32'(e.active));
                check("screen_rst", 32'(screen_rst), 32'(e.rst));
                if (e.chk_dat) begin
                    check("fb_addr", 32'(fb_addr), 32'(e.addr));
                    check("fb_wdata", fb_wdata, e.data);
                end
            end
        end
    end

    initial begin
        logic [3*AW-1:0] pa;
        logic [95:0]     pd;
        bit              hold;
        int              n;

        reset = 1'b1; key_status = '0; s_we = '0; s_addr = '0; s_wdata = '0; s_done = '0;
        m_ph = PH_CLR; m_idx = 0; m_cur = 0; m_age = 0;

        // Reset dominates a same-cycle done; then a full clear pass into RUN on screen 0.
        go(1'b1, 26'd0, 3'b111);
        go(1'b1, 26'd0, 3'b111);
        run_to_run(40);

        // Done on the RUN entry cycle is ignored.
        go(1'b0, 26'd0, 3'b001);
        repeat (3) go(1'b0, 26'd0, 3'b000);

        // Screen 0 finishes; keys during clear ignored, held key stalls WAIT_REL.
        go(1'b0, 26'd0, 3'b001);
        n = 0;
        while (m_ph == PH_CLR && n < 40) begin
            go(1'b0, 26'($urandom), 3'b000);
            n++;
        end
        repeat (10) go(1'b0, 26'h1, 3'b000);
        run_to_run(5);

        // Screen 1 running: all three screens write, only screen 1 reaches the framebuffer.
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 3; i++) begin
                pa[i*AW +: AW] = AW'(16 * (i + 1) + j);
                pd[i*32 +: 32] = 32'hA000_0000 + 32'(i * 256 + j);
            end
            drive(1'b0, 26'd0, 3'b111, pa, pd, 3'b101);
        end

        // GAME -> OVER -> START wrap.
        go(1'b0, 26'd0, 3'b010);
        run_to_run(40);
        go(1'b0, 26'd0, 3'b000);
        go(1'b0, 26'd0, 3'b100);
        run_to_run(40);
        go(1'b0, 26'd0, 3'b000);

        // Reset in the middle of a clear pass together with all done bits.
        go(1'b0, 26'd0, 3'b001);
        n = 0;
        while (m_ph == PH_CLR && m_idx != 7 && n < 40) begin
            go(1'b0, 26'd0, 3'b000);
            n++;
        end
        go(1'b1, 26'd0, 3'b111);
        run_to_run(40);

        // Random traffic: sporadic resets, held keys, random done bits.
        hold = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) hold = ~hold;
            go($urandom_range(0, 299) == 0,
               hold ? 26'(1 << $urandom_range(0, 25)) : 26'd0,
               ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
